risc_8bit_fetch_stage: RTL and testbench

Instruction fetch stage for the 8-bit 5-stage pipelined RISC processor. Owns the program counter and issues word addresses to the synchronous instruction memory. Buffers returned instructions in a small prefetch FIFO and presents them to the decode stage over a valid/ready handshake. Handles branch redirects from EX, decode stalls, and the HALT instruction that ends a program run.

---
 rtl/risc_8bit_fetch_pkg.sv | 11 +
 rtl/risc_8bit_fetch_fifo.sv | 66 ++++++
 rtl/risc_8bit_fetch_stage.sv | 122 ++++++++++++
 tb/tb_risc_8bit_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_8bit_fetch_pkg.sv
// Shared constants for the 8-bit RISC fetch path:
// opcode field width, HALT encoding and default widths.
package risc_8bit_fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int OPC_W       = 4;

  localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

endpackage

// File: rtl/risc_8bit_fetch_fifo.sv
// Prefetch FIFO between instruction memory and decode.
// Flush beats push and pop in the same cycle.
module risc_8bit_fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  assign w_rd = pop && !flush && !empty;
  assign w_wr = push && !flush && (!full || w_rd);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/risc_8bit_fetch_stage.sv
// Fetch stage: PC, imem request issue, prefetch FIFO,
// branch redirect and HALT handling.
module risc_8bit_fetch_stage
  import risc_8bit_fetch_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INSTR_W     = DEF_INSTR_W,
  parameter int                DEPTH       = 2,
  parameter logic [OPC_W-1:0]  HALT_OPCODE = HALT_OPC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               fetch_halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DW    = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;
  logic              r_halt;
  logic [DW-1:0]     r_hold;

  logic [DW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_occ;
  logic [OPC_W-1:0]  w_opc;
  logic              w_pop;
  logic              w_halt_pop;
  logic              w_flush;
  logic              w_room;
  logic              w_issue;

  assign if_valid = !w_empty;
  assign w_opc    = w_head[INSTR_W-1 -: OPC_W];

  assign w_pop      = if_valid && id_ready && !br_taken;
  assign w_halt_pop = w_pop && (w_opc == HALT_OPCODE);
  assign w_flush    = br_taken || w_halt_pop;

  // Slots already promised = stored entries plus the in-flight read.
  assign w_occ  = w_count + CNT_W'(r_inflight);
  assign w_room = w_pop || (!w_full && (w_occ < CNT_W'(DEPTH)));

  assign w_issue = !r_halt && !w_flush && w_room;

  // Nothing may be requested while reset is held.
  assign imem_req  = w_issue && rst_n;
  assign imem_addr = r_pc;

  assign fetch_halted = r_halt;

  // Empty FIFO shows the last instruction delivered.
  assign {if_pc, if_instr} = w_empty ? r_hold : w_head;

  risc_8bit_fetch_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata ({r_req_addr, imem_rdata}),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .rdata (w_head)
  );

  // PC advance/redirect and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (br_taken) begin
        r_pc <= br_target;
      end else if (w_issue) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + ADDR_W'(1);
      end
    end
  end

  // Halt flag: set by a delivered HALT, cleared by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
    end else if (br_taken) begin
      r_halt <= 1'b0;
    end else if (w_halt_pop) begin
      r_halt <= 1'b1;
    end
  end

  // Remember the head so outputs hold while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_empty) begin
      r_hold <= w_head;
    end
  end

endmodule

// File: tb/tb_risc_8bit_fetch_stage.sv
// Directed bench for the fetch stage with a
// delivered-instruction scoreboard.
module tb_risc_8bit_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        id_ready;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        fetch_halted;

  logic [15:0] tb_mem [256];
  logic [7:0]  exp_q [$];
  int          total;
  int          bad;

  risc_8bit_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .fetch_halted (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= tb_mem[imem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [7:0] p;
    if (if_valid && id_ready && !br_taken) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra obs_pc=%0h exp=none", if_pc);
      end
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("sb_pc", {24'h0, if_pc}, {24'h0, p});
        chk("sb_instr", {16'h0, if_instr}, {16'h0, tb_mem[p]});
      end
    end
  endtask

  task automatic tick();
    #1;
    sb_check();
    @(negedge clk);
  endtask

  task automatic push_range(input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'(lo + i));
    end
  endtask

  task automatic wait_head(input logic [7:0] pc, input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (if_valid && if_pc == pc) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'h0, hit}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'(16'h0100 + i);
    imem_rdata = '0;
    rst_n      = 1'b0;
    id_ready   = 1'b1;
    br_taken   = 1'b0;
    br_target  = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 0);
    chk("rst_addr", {24'h0, imem_addr}, 0);
    chk("rst_valid", {31'h0, if_valid}, 0);
    chk("rst_instr", {16'h0, if_instr}, 0);
    chk("rst_pc", {24'h0, if_pc}, 0);
    chk("rst_halt", {31'h0, fetch_halted}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    push_range(0, 30);
    #1;
    chk("c0_req", {31'h0, imem_req}, 1);
    chk("c0_addr", {24'h0, imem_addr}, 0);
    chk("c0_valid", {31'h0, if_valid}, 0);
    tick();
    #1;
    chk("c1_req", {31'h0, imem_req}, 1);
    chk("c1_addr", {24'h0, imem_addr}, 1);
    chk("c1_valid", {31'h0, if_valid}, 0);
    tick();
    #1;
    chk("c2_valid", {31'h0, if_valid}, 1);
    chk("c2_pc", {24'h0, if_pc}, 0);
    chk("c2_instr", {16'h0, if_instr}, 32'h0100);
    tick();

    id_ready = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      #1;
      chk("stall_valid", {31'h0, if_valid}, 1);
      chk("stall_pc", {24'h0, if_pc}, 1);
      chk("stall_req", {31'h0, imem_req}, 0);
      tick();
    end

    id_ready = 1'b1;
    for (int c = 8; c <= 11; c++) begin
      #1;
      chk("resume_valid", {31'h0, if_valid}, 1);
      chk("resume_pc", {24'h0, if_pc}, 32'(c - 7));
      tick();
    end

    br_taken  = 1'b1;
    br_target = 8'h40;
    #1;
    chk("br_req", {31'h0, imem_req}, 0);
    tick();
    br_taken = 1'b0;
    exp_q.delete();
    push_range(8'h40, 16);
    #1;
    chk("br1_req", {31'h0, imem_req}, 1);
    chk("br1_addr", {24'h0, imem_addr}, 32'h40);
    chk("br1_valid", {31'h0, if_valid}, 0);
    tick();
    #1;
    chk("br2_valid", {31'h0, if_valid}, 0);
    tick();
    #1;
    chk("br3_valid", {31'h0, if_valid}, 1);
    chk("br3_pc", {24'h0, if_pc}, 32'h40);
    tick();
    repeat (3) tick();

    id_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("full_req", {31'h0, imem_req}, 0);
    tb_mem[5] = 16'hF000;
    br_taken  = 1'b1;
    br_target = 8'hFE;
    tick();
    br_taken = 1'b0;
    id_ready = 1'b1;
    exp_q.delete();
    push_range(8'hFE, 2);
    push_range(0, 6);
    #1;
    chk("wrap_a0", {24'h0, imem_addr}, 32'hFE);
    chk("wrap_r0", {31'h0, imem_req}, 1);
    tick();
    #1;
    chk("wrap_a1", {24'h0, imem_addr}, 32'hFF);
    chk("wrap_r1", {31'h0, imem_req}, 1);
    tick();
    #1;
    chk("wrap_a2", {24'h0, imem_addr}, 0);
    chk("wrap_r2", {31'h0, imem_req}, 1);
    chk("wrap_pc", {24'h0, if_pc}, 32'hFE);
    tick();

    wait_head(8'h05, "halt_seen");
    chk("halt_instr", {16'h0, if_instr}, 32'hF000);
    tick();
    for (int c = 0; c < 50; c++) begin
      #1;
      chk("halt_flag", {31'h0, fetch_halted}, 1);
      chk("halt_req", {31'h0, imem_req}, 0);
      chk("halt_valid", {31'h0, if_valid}, 0);
      tick();
    end
    chk("halt_q", 32'(exp_q.size()), 0);

    br_taken  = 1'b1;
    br_target = 8'h00;
    #1;
    chk("unhalt_req", {31'h0, imem_req}, 0);
    tick();
    br_taken = 1'b0;
    exp_q.delete();
    push_range(0, 6);
    #1;
    chk("unhalt_flag", {31'h0, fetch_halted}, 0);
    chk("unhalt_req1", {31'h0, imem_req}, 1);
    chk("unhalt_addr", {24'h0, imem_addr}, 0);
    tick();

    wait_head(8'h05, "halt2_seen");
    br_taken  = 1'b1;
    br_target = 8'h20;
    #1;
    chk("brhalt_req", {31'h0, imem_req}, 0);
    tick();
    br_taken = 1'b0;
    exp_q.delete();
    push_range(8'h20, 16);
    #1;
    chk("brhalt_flag", {31'h0, fetch_halted}, 0);
    chk("brhalt_req1", {31'h0, imem_req}, 1);
    chk("brhalt_addr", {24'h0, imem_addr}, 32'h20);
    tick();
    #1;
    chk("brhalt_v2", {31'h0, if_valid}, 0);
    tick();
    #1;
    chk("brhalt_v3", {31'h0, if_valid}, 1);
    chk("brhalt_pc", {24'h0, if_pc}, 32'h20);
    tick();
    repeat (2) tick();

    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'h0, imem_req}, 0);
    chk("mrst_addr", {24'h0, imem_addr}, 0);
    chk("mrst_valid", {31'h0, if_valid}, 0);
    chk("mrst_instr", {16'h0, if_instr}, 0);
    chk("mrst_pc", {24'h0, if_pc}, 0);
    chk("mrst_halt", {31'h0, fetch_halted}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_range(0, 10);
    #1;
    chk("rr_req", {31'h0, imem_req}, 1);
    chk("rr_addr", {24'h0, imem_addr}, 0);
    tick();
    tick();
    #1;
    chk("rr_valid", {31'h0, if_valid}, 1);
    chk("rr_pc", {24'h0, if_pc}, 0);
    tick();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
